// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU instruction sequencer:
// state encoding, default widths and a small state-decode helper.
package cpu_pkg;

    localparam int DEF_PC_WIDTH    = 5;
    localparam int DEF_INSTR_WIDTH = 16;
    localparam int DEF_CNT_WIDTH   = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_HALT    = 3'd4
    } seq_state_t;

    // True while an instruction is in flight.
    function automatic logic is_busy(input seq_state_t st);
        return (st == ST_FETCH) || (st == ST_DECODE) || (st == ST_EXECUTE);
    endfunction

endpackage

// File: rtl/cpu_seq_halt_ctrl.sv
// Halt bookkeeping for cpu_sequencer. Remembers a halt request until the
// next instruction boundary and, when SINGLE_STEP_EN is defined, holds the
// one-shot flag that sends a single-stepped instruction back to HALT.
// The sequencer only sees the combined stop_at_boundary decision.
module cpu_seq_halt_ctrl
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  seq_state_t state,
    input  logic       enter_halt,
    input  logic       halt_req,
`ifdef SINGLE_STEP_EN
    input  logic       run,
    input  logic       step,
`endif
    output logic       stop_at_boundary
);

    logic halt_pending;

    // A request seen outside HALT is remembered until HALT is actually entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_pending <= 1'b0;
        end else if (enter_halt) begin
            halt_pending <= 1'b0;
        end else if (halt_req && (state != ST_HALT)) begin
            halt_pending <= 1'b1;
        end
    end

`ifdef SINGLE_STEP_EN
    logic one_shot;

    // Step from HALT arms the one-shot; run from HALT means free-running, so it disarms.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            one_shot <= 1'b0;
        end else if (enter_halt) begin
            one_shot <= 1'b0;
        end else if ((state == ST_HALT) && !halt_req) begin
            if (run) begin
                one_shot <= 1'b0;
            end else if (step) begin
                one_shot <= 1'b1;
            end
        end
    end

    // A request arriving in the boundary cycle itself still stops at that boundary.
    assign stop_at_boundary = halt_pending | halt_req | one_shot;
`else
    // A request arriving in the boundary cycle itself still stops at that boundary.
    assign stop_at_boundary = halt_pending | halt_req;
`endif

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer for the 16-bit CPU datapath.
// Owns pc, ir and the retired-instruction counter, walks each instruction
// through FETCH -> DECODE -> EXECUTE and issues one-cycle Moore enables.
// Instructions failing their condition are retired from DECODE without
// EXECUTE. Halts only take effect at instruction boundaries.
// Optional feature: define SINGLE_STEP_EN to add the step port and the
// single-step one-shot behaviour out of HALT.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH    = DEF_PC_WIDTH,
    parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic                   halt_req,
    output logic [PC_WIDTH-1:0]    rom_addr,
    output logic                   rom_req,
    input  logic [INSTR_WIDTH-1:0] rom_rdata,
    input  logic                   rom_ready,
    output logic [INSTR_WIDTH-1:0] ir,
    input  logic                   cond_pass,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    output logic                   dec_en,
    output logic                   alu_en,
    output logic                   rf_we,
    output logic                   flags_en,
    output logic                   busy,
    output logic                   halted,
`ifdef SINGLE_STEP_EN
    input  logic                   step,
`endif
    output logic [CNT_WIDTH-1:0]   retired
);

    seq_state_t          state;
    seq_state_t          state_nxt;
    logic [PC_WIDTH-1:0] pc;
    logic                stop_at_boundary;
    logic                enter_halt;
    logic                fetch_done;
    logic                retire;
    logic                step_go;

`ifdef SINGLE_STEP_EN
    assign step_go = step;
`else
    assign step_go = 1'b0;
`endif

    cpu_seq_halt_ctrl u_halt_ctrl (
        .clk              (clk),
        .rst              (rst),
        .state            (state),
        .enter_halt       (enter_halt),
        .halt_req         (halt_req),
`ifdef SINGLE_STEP_EN
        .run              (run),
        .step             (step),
`endif
        .stop_at_boundary (stop_at_boundary)
    );

    // State register; reset drops straight to IDLE so every enable falls immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic plus Moore outputs decoded from the registered state.
    always_comb begin
        state_nxt  = state;
        rom_req    = 1'b0;
        dec_en     = 1'b0;
        alu_en     = 1'b0;
        rf_we      = 1'b0;
        flags_en   = 1'b0;
        halted     = 1'b0;
        fetch_done = 1'b0;
        retire     = 1'b0;
        enter_halt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                rom_req = 1'b1;
                if (rom_ready) begin
                    fetch_done = 1'b1;
                    state_nxt  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                dec_en = 1'b1;
                if (cond_pass) begin
                    state_nxt = ST_EXECUTE;
                end else begin
                    // Skipped instruction: this edge is an instruction boundary.
                    retire = 1'b1;
                    if (stop_at_boundary) begin
                        enter_halt = 1'b1;
                        state_nxt  = ST_HALT;
                    end else begin
                        state_nxt = ST_FETCH;
                    end
                end
            end
            ST_EXECUTE: begin
                alu_en   = 1'b1;
                rf_we    = 1'b1;
                flags_en = 1'b1;
                retire   = 1'b1;
                if (stop_at_boundary) begin
                    enter_halt = 1'b1;
                    state_nxt  = ST_HALT;
                end else begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
                // A simultaneous halt request keeps us parked.
                if (!halt_req && (run || step_go)) begin
                    state_nxt = ST_FETCH;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy     = is_busy(state);
    assign rom_addr = pc;

    // Program counter: increment on fetch, a taken branch in EXECUTE overrides it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
        end else if (fetch_done) begin
            pc <= pc + PC_WIDTH'(1);
        end else if ((state == ST_EXECUTE) && branch_taken) begin
            pc <= branch_target;
        end
    end

    // Instruction register loads only when the ROM word is valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir <= '0;
        end else if (fetch_done) begin
            ir <= rom_rdata;
        end
    end

    // Retired count covers executed and skipped instructions, wrapping naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired <= '0;
        end else if (retire) begin
            retired <= retired + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed scenarios followed by randomized
// instruction streams, checked against an instruction-level reference model.
module tb_cpu_sequencer;

    localparam int PCW = 5;
    localparam int IW  = 16;
    localparam int CW  = 16;

    // Control vector order: {rom_req, dec_en, alu_en, rf_we, flags_en, busy, halted}
    localparam logic [6:0] C_IDLE  = 7'b0000000;
    localparam logic [6:0] C_FETCH = 7'b1000010;
    localparam logic [6:0] C_DEC   = 7'b0100010;
    localparam logic [6:0] C_EXEC  = 7'b0011110;
    localparam logic [6:0] C_HALT  = 7'b0000001;

    logic           clk = 1'b0;
    logic           rst;
    logic           run;
    logic           halt_req;
    logic [PCW-1:0] rom_addr;
    logic           rom_req;
    logic [IW-1:0]  rom_rdata;
    logic           rom_ready;
    logic [IW-1:0]  ir;
    logic           cond_pass;
    logic           branch_taken;
    logic [PCW-1:0] branch_target;
    logic           dec_en;
    logic           alu_en;
    logic           rf_we;
    logic           flags_en;
    logic           busy;
    logic           halted;
    logic           step;
    logic [CW-1:0]  retired;
    logic [6:0]     ctl;

    assign ctl = {rom_req, dec_en, alu_en, rf_we, flags_en, busy, halted};

    cpu_sequencer #(
        .PC_WIDTH    (PCW),
        .INSTR_WIDTH (IW),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .halt_req      (halt_req),
        .rom_addr      (rom_addr),
        .rom_req       (rom_req),
        .rom_rdata     (rom_rdata),
        .rom_ready     (rom_ready),
        .ir            (ir),
        .cond_pass     (cond_pass),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .dec_en        (dec_en),
        .alu_en        (alu_en),
        .rf_we         (rf_we),
        .flags_en      (flags_en),
        .busy          (busy),
        .halted        (halted),
`ifdef SINGLE_STEP_EN
        .step          (step),
`endif
        .retired       (retired)
    );

    always #5 clk = ~clk;

    // Reference model: architectural state at instruction granularity.
    logic [PCW-1:0] m_pc;
    logic [IW-1:0]  m_ir;
    logic [CW-1:0]  m_ret;
    bit             m_pend;
    bit             m_halted;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc     = '0;
        m_ir     = '0;
        m_ret    = '0;
        m_pend   = 1'b0;
        m_halted = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ctl"}, 32'(ctl), 32'(C_IDLE));
        chk({tag, "_addr"}, 32'(rom_addr), 32'd0);
        chk({tag, "_ir"}, 32'(ir), 32'd0);
        chk({tag, "_ret"}, 32'(retired), 32'd0);
    endtask

    task automatic drive_halt(input int c, input int hpos);
        halt_req = (c == hpos);
        if (c == hpos) m_pend = 1'b1;
    endtask

    // One instruction, entered while the DUT is in FETCH. hpos selects the
    // cycle (counted from the first FETCH cycle) carrying a halt_req pulse.
    task automatic instr(input int nwait, input bit cond, input bit br,
                         input logic [PCW-1:0] tgt, input int hpos);
        logic [IW-1:0] w;
        int c;
        w = IW'($urandom);
        c = 0;
        for (int k = 0; k <= nwait; k++) begin
            chk("fetch_ctl", 32'(ctl), 32'(C_FETCH));
            chk("fetch_addr", 32'(rom_addr), 32'(m_pc));
            chk("fetch_ir", 32'(ir), 32'(m_ir));
            rom_ready     = (k == nwait);
            rom_rdata     = (k == nwait) ? w : IW'($urandom);
            cond_pass     = 1'($urandom);
            branch_taken  = 1'($urandom);
            branch_target = PCW'($urandom);
            run           = 1'($urandom);
            drive_halt(c, hpos);
            @(negedge clk);
            c++;
        end
        m_pc = m_pc + 5'd1;
        m_ir = w;
        chk("dec_ctl", 32'(ctl), 32'(C_DEC));
        chk("dec_addr", 32'(rom_addr), 32'(m_pc));
        chk("dec_ir", 32'(ir), 32'(m_ir));
        rom_ready     = 1'($urandom);
        rom_rdata     = IW'($urandom);
        cond_pass     = cond;
        branch_taken  = 1'($urandom);
        branch_target = PCW'($urandom);
        drive_halt(c, hpos);
        @(negedge clk);
        c++;
        if (cond) begin
            chk("exec_ctl", 32'(ctl), 32'(C_EXEC));
            chk("exec_ir", 32'(ir), 32'(m_ir));
            rom_ready     = 1'($urandom);
            cond_pass     = 1'($urandom);
            branch_taken  = br;
            branch_target = tgt;
            drive_halt(c, hpos);
            @(negedge clk);
            c++;
            if (br) m_pc = tgt;
        end
        halt_req = 1'b0;
        run      = 1'b0;
        m_ret    = m_ret + 16'd1;
        if (m_pend) begin
            m_halted = 1'b1;
            m_pend   = 1'b0;
        end
        chk("bound_ctl", 32'(ctl), 32'(m_halted ? C_HALT : C_FETCH));
        chk("bound_addr", 32'(rom_addr), 32'(m_pc));
        chk("bound_ret", 32'(retired), 32'(m_ret));
    endtask

    // Sit in HALT for a while, optionally try run+halt_req together, then resume with run.
    task automatic resume(input int idle, input bit clash);
        for (int k = 0; k < idle; k++) begin
            chk("halt_ctl", 32'(ctl), 32'(C_HALT));
            chk("halt_addr", 32'(rom_addr), 32'(m_pc));
            chk("halt_ir", 32'(ir), 32'(m_ir));
            chk("halt_ret", 32'(retired), 32'(m_ret));
            run      = 1'b0;
            halt_req = 1'($urandom);
            @(negedge clk);
        end
        if (clash) begin
            run      = 1'b1;
            halt_req = 1'b1;
            @(negedge clk);
            chk("clash_ctl", 32'(ctl), 32'(C_HALT));
        end
        run      = 1'b1;
        halt_req = 1'b0;
        @(negedge clk);
        run      = 1'b0;
        m_halted = 1'b0;
        chk("resume_ctl", 32'(ctl), 32'(C_FETCH));
        chk("resume_addr", 32'(rom_addr), 32'(m_pc));
    endtask

    // Leave IDLE: stays idle while run is low, then fetches.
    task automatic start();
        chk("idle_ctl", 32'(ctl), 32'(C_IDLE));
        run = 1'b0;
        @(negedge clk);
        chk("idle_hold", 32'(ctl), 32'(C_IDLE));
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        chk("start_ctl", 32'(ctl), 32'(C_FETCH));
        chk("start_addr", 32'(rom_addr), 32'(m_pc));
    endtask

    // Enter at FETCH, proceed into EXECUTE and hit async reset between edges.
    task automatic reset_mid_exec();
        rom_ready = 1'b1;
        rom_rdata = IW'($urandom);
        @(negedge clk);
        chk("rx_dec", 32'(ctl), 32'(C_DEC));
        cond_pass = 1'b1;
        @(negedge clk);
        chk("rx_exec", 32'(ctl), 32'(C_EXEC));
        #2 rst = 1'b1;
        #1 check_reset_vals("rst_async");
        @(negedge clk);
        check_reset_vals("rst_hold");
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  nwait;
        int  ncyc;
        int  hpos;
        bit  cond;
        bit  br;

        rst = 1'b1; run = 1'b0; halt_req = 1'b0; step = 1'b0;
        rom_ready = 1'b0; rom_rdata = '0; cond_pass = 1'b0;
        branch_taken = 1'b0; branch_target = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;

        // Three straight-line executed instructions from pc 0.
        start();
        for (int i = 0; i < 3; i++) instr(0, 1'b1, 1'b0, 5'd0, -1);
        chk("three_ret", 32'(retired), 32'd3);
        chk("three_addr", 32'(rom_addr), 32'd3);

        reset_mid_exec();

        // Halt requested while idle stops at the first boundary.
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        m_pend   = 1'b1;
        start();
        instr(0, 1'b1, 1'b0, 5'd0, -1);
        resume(1, 1'b0);

        // Skip at pc 1, branch to 7 at pc 2, branch to 31, wrap, ROM stall, halt in FETCH.
        instr(0, 1'b0, 1'b1, 5'd9, -1);
        instr(0, 1'b1, 1'b1, 5'd7, -1);
        chk("branch7", 32'(rom_addr), 32'd7);
        instr(0, 1'b1, 1'b1, 5'd31, -1);
        instr(0, 1'b1, 1'b0, 5'd0, -1);
        chk("wrap0", 32'(rom_addr), 32'd0);
        instr(4, 1'b1, 1'b0, 5'd0, -1);
        instr(0, 1'b1, 1'b0, 5'd0, 0);
        resume(2, 1'b1);

        // Randomized instruction stream.
        for (int i = 0; i < 150; i++) begin
            if (m_halted) resume($urandom_range(0, 2), ($urandom_range(0, 3) == 0));
            nwait = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            cond  = ($urandom_range(0, 3) != 0);
            br    = 1'($urandom);
            ncyc  = nwait + 2 + int'(cond);
            hpos  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, ncyc - 1) : -1;
            instr(nwait, cond, br, PCW'($urandom), hpos);
        end

`ifdef SINGLE_STEP_EN
        if (!m_halted) instr(0, 1'b1, 1'b0, 5'd0, 0);
        // Step alone: exactly one instruction, then back to HALT.
        step = 1'b1; run = 1'b0;
        @(negedge clk);
        step = 1'b0;
        m_halted = 1'b0;
        m_pend   = 1'b1;
        chk("step_ctl", 32'(ctl), 32'(C_FETCH));
        instr(0, 1'b1, 1'($urandom), PCW'($urandom), -1);
        chk("step_halted", 32'(halted), 32'd1);
        // Step with run: run wins, the machine keeps running.
        step = 1'b1; run = 1'b1;
        @(negedge clk);
        step = 1'b0; run = 1'b0;
        m_halted = 1'b0;
        chk("steprun_ctl", 32'(ctl), 32'(C_FETCH));
        instr(0, 1'b1, 1'b0, 5'd0, -1);
        instr(0, 1'b0, 1'b0, 5'd0, -1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
